// File: rtl/sampler_pkg.sv
// Shared types and constants for multi_sampler.
// The mode map depends on the SAMPLER_MIX_EN macro: without it, mix requests fall back to left.
package sampler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } sampler_state_t;

    localparam logic [1:0] MODE_LEFT  = 2'd0;
    localparam logic [1:0] MODE_RIGHT = 2'd1;
    localparam logic [1:0] MODE_MIX   = 2'd2;

    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_WIN_LEN   = 2048;
    localparam int DEF_NUM_SLOTS = 4;

    // Collapse the 2-bit mode request onto the modes this build supports (3 = left).
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        logic [1:0] r;
        r = MODE_LEFT;
        if (m == MODE_RIGHT) r = MODE_RIGHT;
`ifdef SAMPLER_MIX_EN
        if (m == MODE_MIX) r = MODE_MIX;
`endif
        return r;
    endfunction

endpackage

// File: rtl/sample_mixer.sv
// Combinational signed average of two samples: (l + r) >>> 1, rounding toward -inf.
// Only instantiated when SAMPLER_MIX_EN is defined.
module sample_mixer #(
    parameter int SAMPLE_W = 16
) (
    input  logic [SAMPLE_W-1:0] left,
    input  logic [SAMPLE_W-1:0] right,
    output logic [SAMPLE_W-1:0] mix
);

    logic signed [SAMPLE_W:0] sum;

    // One extra bit keeps the sum from overflowing; the arithmetic shift floors the halving.
    assign sum = $signed({left[SAMPLE_W-1], left}) + $signed({right[SAMPLE_W-1], right});
    assign mix = SAMPLE_W'(sum >>> 1);

endmodule

// File: rtl/multi_sampler.sv
// Codec stream sampler: picks left/right/mix, writes a windowed ring buffer,
// pulses go_out per completed slot and flags consumer overrun.
// Optional feature macro: SAMPLER_MIX_EN (L/R average in mode 2; otherwise mode 2 = left).
module multi_sampler
    import sampler_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int WIN_LEN   = DEF_WIN_LEN,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int ADDR_W    = $clog2(WIN_LEN * NUM_SLOTS),
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SAMPLE_W-1:0] left_in_data,
    input  logic                left_in_valid,
    output logic                left_in_ready,
    input  logic [SAMPLE_W-1:0] right_in_data,
    input  logic                right_in_valid,
    output logic                right_in_ready,
    output logic [SAMPLE_W-1:0] ring_buf_data,
    output logic [ADDR_W-1:0]   ring_buf_addr,
    output logic                ring_buf_wren,
    output logic [SLOT_W-1:0]   window_start,
    output logic                go_out,
    input  logic                ack_in,
    input  logic                clr_overrun,
    output logic                overrun
);

    localparam logic [ADDR_W-1:0] WIN_MASK = ADDR_W'(WIN_LEN - 1);

    sampler_state_t      state_q, state_d;
    logic [1:0]          active_mode_q, active_mode_d;
    logic                left_ready_d, right_ready_d;
    logic                wren_d, go_d;
    logic [SAMPLE_W-1:0] data_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [SLOT_W-1:0]   win_d;
    logic                pending;
    logic                left_acc, right_acc, slot_end;

    assign left_acc  = left_in_ready && left_in_valid;
    assign right_acc = right_in_ready && right_in_valid;
    assign slot_end  = (ring_buf_addr & WIN_MASK) == WIN_MASK;

`ifdef SAMPLER_MIX_EN
    logic                left_held_q, left_held_d, right_held_q, right_held_d;
    logic [SAMPLE_W-1:0] left_hold_q, left_hold_d, right_hold_q, right_hold_d;
    logic [SAMPLE_W-1:0] mix_left, mix_right, mix_out;

    // A channel arriving this cycle bypasses its holding register.
    assign mix_left  = left_held_q  ? left_hold_q  : left_in_data;
    assign mix_right = right_held_q ? right_hold_q : right_in_data;

    sample_mixer #(.SAMPLE_W(SAMPLE_W)) u_mixer (
        .left  (mix_left),
        .right (mix_right),
        .mix   (mix_out)
    );
`endif

    // Next-state, capture and next-output decode for the IDLE/COLLECT/WRITE sequencer.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_d       = state_q;
        active_mode_d = active_mode_q;
        wren_d        = 1'b0;
        go_d          = 1'b0;
        data_d        = ring_buf_data;
        addr_d        = ring_buf_addr;
        win_d         = window_start;
`ifdef SAMPLER_MIX_EN
        left_held_d   = left_held_q;
        right_held_d  = right_held_q;
        left_hold_d   = left_hold_q;
        right_hold_d  = right_hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    active_mode_d = map_mode(mode);
                    state_d       = COLLECT;
                end
            end
            COLLECT: begin
                if (!en) begin
                    state_d = IDLE;
`ifdef SAMPLER_MIX_EN
                    left_held_d  = 1'b0;
                    right_held_d = 1'b0;
`endif
                end
`ifdef SAMPLER_MIX_EN
                else if (active_mode_q == MODE_MIX) begin
                    if (left_acc) begin
                        left_held_d = 1'b1;
                        left_hold_d = left_in_data;
                    end
                    if (right_acc) begin
                        right_held_d = 1'b1;
                        right_hold_d = right_in_data;
                    end
                    if (left_held_d && right_held_d) begin
                        data_d       = mix_out;
                        wren_d       = 1'b1;
                        state_d      = WRITE;
                        left_held_d  = 1'b0;
                        right_held_d = 1'b0;
                    end
                end
`endif
                else if (active_mode_q == MODE_RIGHT) begin
                    if (right_acc) begin
                        data_d  = right_in_data;
                        wren_d  = 1'b1;
                        state_d = WRITE;
                    end
                end else begin
                    if (left_acc) begin
                        data_d  = left_in_data;
                        wren_d  = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d = ring_buf_addr + ADDR_W'(1);
                if (slot_end) begin
                    go_d          = 1'b1;
                    win_d         = ring_buf_addr[ADDR_W-1 -: SLOT_W];
                    active_mode_d = map_mode(mode);
                end
                state_d = en ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Readies are registered: open in COLLECT until that channel's mix sample is held.
        left_ready_d  = (state_d == COLLECT);
        right_ready_d = (state_d == COLLECT);
`ifdef SAMPLER_MIX_EN
        left_ready_d  = left_ready_d  && !left_held_d;
        right_ready_d = right_ready_d && !right_held_d;
`endif
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q        <= IDLE;
            active_mode_q  <= MODE_LEFT;
            left_in_ready  <= 1'b0;
            right_in_ready <= 1'b0;
            ring_buf_wren  <= 1'b0;
            ring_buf_data  <= '0;
            ring_buf_addr  <= '0;
            window_start   <= SLOT_W'(NUM_SLOTS - 1);
            go_out         <= 1'b0;
`ifdef SAMPLER_MIX_EN
            left_held_q    <= 1'b0;
            right_held_q   <= 1'b0;
            left_hold_q    <= '0;
            right_hold_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            active_mode_q  <= active_mode_d;
            left_in_ready  <= left_ready_d;
            right_in_ready <= right_ready_d;
            ring_buf_wren  <= wren_d;
            ring_buf_data  <= data_d;
            ring_buf_addr  <= addr_d;
            window_start   <= win_d;
            go_out         <= go_d;
`ifdef SAMPLER_MIX_EN
            left_held_q    <= left_held_d;
            right_held_q   <= right_held_d;
            left_hold_q    <= left_hold_d;
            right_hold_q   <= right_hold_d;
`endif
        end
    end

    // Consumer tracking: an ack alongside go_out retires the old window; a new overrun beats clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (go_out)      pending <= 1'b1;
            else if (ack_in) pending <= 1'b0;

            if (go_out && pending && !ack_in) overrun <= 1'b1;
            else if (clr_overrun)             overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_sampler.sv
// Self-checking bench for multi_sampler at default parameters, with a window-level
// reference model (expected address, slot, pending/overrun, sample value by mode).
module tb_multi_sampler;

    localparam int SAMPLE_W  = 16;
    localparam int WIN_LEN   = 2048;
    localparam int NUM_SLOTS = 4;
    localparam int ADDR_W    = 13;
    localparam int SLOT_W    = 2;
    localparam int DEPTH     = WIN_LEN * NUM_SLOTS;
`ifdef SAMPLER_MIX_EN
    localparam bit MIX_EN = 1'b1;
`else
    localparam bit MIX_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset_n;
    logic                en;
    logic [1:0]          mode;
    logic [SAMPLE_W-1:0] left_in_data, right_in_data;
    logic                left_in_valid, right_in_valid;
    logic                left_in_ready, right_in_ready;
    logic [SAMPLE_W-1:0] ring_buf_data;
    logic [ADDR_W-1:0]   ring_buf_addr;
    logic                ring_buf_wren;
    logic [SLOT_W-1:0]   window_start;
    logic                go_out;
    logic                ack_in, clr_overrun;
    logic                overrun;

    multi_sampler #(
        .SAMPLE_W  (SAMPLE_W),
        .WIN_LEN   (WIN_LEN),
        .NUM_SLOTS (NUM_SLOTS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en             (en),
        .mode           (mode),
        .left_in_data   (left_in_data),
        .left_in_valid  (left_in_valid),
        .left_in_ready  (left_in_ready),
        .right_in_data  (right_in_data),
        .right_in_valid (right_in_valid),
        .right_in_ready (right_in_ready),
        .ring_buf_data  (ring_buf_data),
        .ring_buf_addr  (ring_buf_addr),
        .ring_buf_wren  (ring_buf_wren),
        .window_start   (window_start),
        .go_out         (go_out),
        .ack_in         (ack_in),
        .clr_overrun    (clr_overrun),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: 0 = left, 1 = right, 2 = mix.
    int exp_addr;
    int exp_ws;
    bit exp_pend;
    bit exp_ovr;
    int cur_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_mode(input logic [1:0] m);
        if (m == 2'd1) return 1;
        if (m == 2'd2 && MIX_EN) return 2;
        return 0;
    endfunction

    // Mix is the floor of the exact average of the two signed samples.
    function automatic logic [15:0] expect_sample(input int m, input logic [15:0] l, input logic [15:0] r);
        int s;
        if (m == 0) return l;
        if (m == 1) return r;
        s = int'($signed(l)) + int'($signed(r));
        if (s < 0 && (s % 2) != 0) s = s - 1;
        return 16'(s / 2);
    endfunction

    task automatic tick();
        @(negedge clk);
        ack_in      = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_left_ready"},  left_in_ready, 0);
        check({tag, "_right_ready"}, right_in_ready, 0);
        check({tag, "_wren"},        ring_buf_wren, 0);
        check({tag, "_addr"},        ring_buf_addr, 0);
        check({tag, "_data"},        ring_buf_data, 0);
        check({tag, "_window"},      window_start, NUM_SLOTS - 1);
        check({tag, "_go"},          go_out, 0);
        check({tag, "_overrun"},     overrun, 0);
    endtask

    // Offer one sample (per-channel start delays), then check the write and the slot pulse.
    // Called and returns on a negedge; ack/clr are driven in the go_out cycle.
    task automatic sample(input logic [15:0] l, input logic [15:0] r, input int ld, input int rd,
                          input bit ack, input bit clr);
        bit          lp = 1'b1;
        bit          rp = 1'b1;
        bit          done = 1'b0;
        bit          need_l, need_r, boundary;
        int          t = 0;
        logic [15:0] exp_d;
        need_l = (cur_mode != 1);
        need_r = (cur_mode != 0);
        exp_d  = expect_sample(cur_mode, l, r);
        left_in_data  = l;
        right_in_data = r;
        while (!done && t <= 64) begin
            if (cur_mode == 2 && !lp && rp) check("mix_left_ready_held", left_in_ready, 0);
            if (cur_mode == 2 && !rp && lp) check("mix_right_ready_held", right_in_ready, 0);
            left_in_valid  = lp && (t >= ld);
            right_in_valid = rp && (t >= rd);
            if (left_in_valid && left_in_ready)   lp = 1'b0;
            if (right_in_valid && right_in_ready) rp = 1'b0;
            done = !(need_l && lp) && !(need_r && rp);
            tick();
            t++;
        end
        left_in_valid  = 1'b0;
        right_in_valid = 1'b0;
        check("accept_done", done, 1);
        check("write_wren",        ring_buf_wren, 1);
        check("write_addr",        ring_buf_addr, exp_addr);
        check("write_data",        ring_buf_data, exp_d);
        check("write_left_ready",  left_in_ready, 0);
        check("write_right_ready", right_in_ready, 0);
        check("write_go",          go_out, 0);
        check("overrun",           overrun, exp_ovr);
        boundary = (exp_addr % WIN_LEN) == (WIN_LEN - 1);
        if (boundary) exp_ws = exp_addr / WIN_LEN;
        tick();
        ack_in      = ack;
        clr_overrun = clr;
        check("post_wren",   ring_buf_wren, 0);
        check("post_go",     go_out, boundary);
        check("post_window", window_start, exp_ws);
        if (boundary) begin
            if (exp_pend && !ack) exp_ovr = 1'b1;
            else if (clr)         exp_ovr = 1'b0;
            exp_pend = 1'b1;
            cur_mode = eff_mode(mode);
        end else begin
            if (ack) exp_pend = 1'b0;
            if (clr) exp_ovr  = 1'b0;
        end
        exp_addr = (exp_addr + 1) % DEPTH;
    endtask

    // Random sample; at a slot's last address also pick a random mode for the next window.
    task automatic rand_sample(input bit ack, input bit clr);
        int max_d;
        if ((exp_addr % WIN_LEN) == (WIN_LEN - 1)) mode = 2'($urandom_range(0, 3));
        max_d = (cur_mode == 2) ? 3 : 1;
        sample(16'($urandom), 16'($urandom), int'($urandom_range(0, max_d)),
               int'($urandom_range(0, max_d)), ack, clr);
    endtask

    task automatic run_to(input int target);
        while (exp_addr != target) rand_sample(1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        en             = 1'b0;
        mode           = 2'd0;
        left_in_data   = '0;
        right_in_data  = '0;
        left_in_valid  = 1'b0;
        right_in_valid = 1'b0;
        ack_in         = 1'b0;
        clr_overrun    = 1'b0;
        exp_addr = 0;
        exp_ws   = NUM_SLOTS - 1;
        exp_pend = 1'b0;
        exp_ovr  = 1'b0;
        cur_mode = 0;

        // Reset state.
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("idle_left_ready", left_in_ready, 0);

        // Left mode, basic writes; right beats are drained alongside.
        en   = 1'b1;
        mode = 2'd0;
        cur_mode = eff_mode(mode);
        sample(16'h0001, 16'($urandom), 0, 0, 1'b0, 1'b0);
        sample(16'h0002, 16'($urandom), 0, 0, 1'b0, 1'b0);
        sample(16'h0003, 16'($urandom), 1, 0, 1'b0, 1'b0);

        // Enable gating after addr 100: readies close, nothing is written.
        run_to(100);
        rand_sample(1'b0, 1'b0);
        en = 1'b0;
        tick();
        left_in_valid  = 1'b1;
        right_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("gated_left_ready",  left_in_ready, 0);
            check("gated_right_ready", right_in_ready, 0);
            check("gated_wren",        ring_buf_wren, 0);
            tick();
        end
        left_in_valid  = 1'b0;
        right_in_valid = 1'b0;

        // Re-enable in mix mode; capture resumes at addr 101.
        mode = 2'd2;
        en   = 1'b1;
        cur_mode = eff_mode(mode);
        tick();
        sample(16'h7FFF, 16'h7FFF, 0, 0, 1'b0, 1'b0);
        sample(16'h8000, 16'hFFFF, 0, 0, 1'b0, 1'b0);
        sample(16'hFFFF, 16'h0000, 0, 0, 1'b0, 1'b0);
        sample(16'h7FFF, 16'h7FFF, 0, 3, 1'b0, 1'b0);
        sample(16'h8000, 16'hFFFF, 0, 3, 1'b0, 1'b0);
        sample(16'hFFFF, 16'h0000, 0, 3, 1'b0, 1'b0);
        sample(16'h8000, 16'hFFFF, 2, 0, 1'b0, 1'b0);

        // Slot 0 completes unacknowledged.
        run_to(WIN_LEN - 1);
        rand_sample(1'b0, 1'b0);

        // Slot 1 completes while slot 0 is pending; a coincident clr loses to the new overrun.
        run_to(2 * WIN_LEN - 1);
        rand_sample(1'b0, 1'b1);
        tick();
        check("overrun_set", overrun, exp_ovr);
        clr_overrun = 1'b1;
        exp_ovr = 1'b0;
        tick();
        check("overrun_cleared", overrun, exp_ovr);

        // Slots 2 and 3 complete with ack coincident with go_out: no overrun.
        run_to(3 * WIN_LEN - 1);
        rand_sample(1'b1, 1'b0);
        tick();
        check("ack_with_go_no_overrun", overrun, exp_ovr);
        run_to(DEPTH - 1);
        rand_sample(1'b1, 1'b0);
        rand_sample(1'b0, 1'b0);
        rand_sample(1'b0, 1'b0);

        // Reset mid-operation with a left sample taken in mix mode.
        en = 1'b0;
        tick();
        tick();
        mode = 2'd2;
        en   = 1'b1;
        tick();
        left_in_data  = 16'($urandom);
        left_in_valid = 1'b1;
        tick();
        left_in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        reset_n  = 1'b1;
        exp_addr = 0;
        exp_ws   = NUM_SLOTS - 1;
        exp_pend = 1'b0;
        exp_ovr  = 1'b0;
        cur_mode = eff_mode(mode);
        sample(16'h1235, 16'hF002, 0, 1, 1'b0, 1'b0);
        rand_sample(1'b0, 1'b0);
        rand_sample(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
